// File: rtl/vme_irq_pkg.sv
// -----------------------------------------------------------------------------
// vme_irq_pkg
// Shared definitions for the VME interrupter (vme_irq_ctrl):
//   - state_e     : IACK-cycle FSM states
//   - SYNC_DEPTH  : number of flops in every asynchronous-input synchroniser
//   - prio_t      : result of the priority encoder (valid + index)
//   - prio_enc()  : lowest-set-bit priority encoder, bit 0 = highest priority
// -----------------------------------------------------------------------------
package vme_irq_pkg;

  localparam int SYNC_DEPTH = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_RESPOND,
    ST_HOLD,
    ST_PASS,
    ST_WAIT_END
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } prio_t;

  // Scans from the top down so the last hit, i.e. the lowest set bit, wins.
  function automatic prio_t prio_enc(input logic [7:0] req);
    prio_t res;
    res = '0;
    for (int i = 7; i >= 0; i--) begin
      if (req[i]) begin
        res.valid = 1'b1;
        res.idx   = 3'(i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/vme_irq_sync.sv
// -----------------------------------------------------------------------------
// vme_irq_sync
// Generic WIDTH-bit multi-flop synchroniser (depth SYNC_DEPTH). Each bit is
// synchronised independently; the flops reset to RESET_VAL so active-low
// inputs come out of reset in their inactive state.
// Ports:
//   clk_i   : destination clock
//   rst_ni  : asynchronous active-low reset
//   d_i     : asynchronous input bits
//   q_o     : synchronised output bits
// -----------------------------------------------------------------------------
module vme_irq_sync
  import vme_irq_pkg::*;
#(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [SYNC_DEPTH-1:0][WIDTH-1:0] stage_q;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge value of its neighbour; blocking here would
  // collapse the chain into a single flop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_q <= {SYNC_DEPTH{RESET_VAL}};
    end else begin
      stage_q <= {stage_q[SYNC_DEPTH-2:0], d_i};
    end
  end

  assign q_o = stage_q[SYNC_DEPTH-1];

endmodule

// File: rtl/vme_irq_ctrl.sv
// -----------------------------------------------------------------------------
// vme_irq_ctrl
// VME ROAK D08(O) interrupter. Latches falling edges of the local interrupt
// lines into PENDING, requests on IRQn while any enabled bit is pending, and
// answers IACK cycles on its own level with VECTOR_BASE + source index, or
// passes the IACK daisy chain onward.
// Ports:
//   CLOCK, RESETn : clock, asynchronous active-low reset
//   LINTIn        : local interrupts, active low, asynchronous
//   IRQ_MASK      : 1 = source may request
//   VME_ASn, DS0n, IACKn, IACKINn : VME strobes / daisy-chain in, asynchronous
//   ADDR_LVL      : A[3:1] during IACK, sampled when synced VME_ASn falls
//   IACKOUTn      : daisy-chain out
//   IRQn          : interrupt request, active low
//   VECTOR, VEC_OE: status/ID byte and its data-buffer drive enable
//   IRQ_DTACKn    : DTACK contribution, active low
//   PENDING       : latched pending bits
// -----------------------------------------------------------------------------
module vme_irq_ctrl
  import vme_irq_pkg::*;
#(
  parameter int         NUM_SRC     = 8,
  parameter int         IRQ_LEVEL   = 1,
  parameter logic [7:0] VECTOR_BASE = 8'h40,
  parameter int         DTACK_DLY   = 2
) (
  input  logic               CLOCK,
  input  logic               RESETn,
  input  logic [NUM_SRC-1:0] LINTIn,
  input  logic [NUM_SRC-1:0] IRQ_MASK,
  input  logic               VME_ASn,
  input  logic               DS0n,
  input  logic               IACKn,
  input  logic               IACKINn,
  input  logic [2:0]         ADDR_LVL,
  output logic               IACKOUTn,
  output logic               IRQn,
  output logic [7:0]         VECTOR,
  output logic               VEC_OE,
  output logic               IRQ_DTACKn,
  output logic [NUM_SRC-1:0] PENDING
);

  localparam int                CNT_W    = (DTACK_DLY > 1) ? $clog2(DTACK_DLY) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DTACK_DLY - 1);

  // Synchronised inputs
  logic [NUM_SRC-1:0] lint_s;
  logic               as_s, ds_s, iack_s, iackin_s;

  vme_irq_sync #(.WIDTH(NUM_SRC), .RESET_VAL({NUM_SRC{1'b1}})) u_sync_lint (
    .clk_i  (CLOCK),
    .rst_ni (RESETn),
    .d_i    (LINTIn),
    .q_o    (lint_s)
  );

  vme_irq_sync #(.WIDTH(4), .RESET_VAL(4'hF)) u_sync_vme (
    .clk_i  (CLOCK),
    .rst_ni (RESETn),
    .d_i    ({VME_ASn, DS0n, IACKn, IACKINn}),
    .q_o    ({as_s, ds_s, iack_s, iackin_s})
  );

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] lint_prev_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic               irq_n_q;
  logic               as_prev_q;
  logic [2:0]         lvl_q;
  logic               req_q;
  logic [2:0]         sel_q, sel_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ack_clr;
  logic [7:0]         clr8;
  prio_t              prio_m, prio_p;

  // Enabled-and-pending sources first; if the mask was cleared after the
  // request was latched, fall back to the lowest pending bit.
  assign prio_m = prio_enc(8'(pending_q & IRQ_MASK));
  assign prio_p = prio_enc(8'(pending_q));

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    ack_clr = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!iack_s && !as_s && !ds_s) state_d = ST_ARB;
      end
      ST_ARB: begin
        state_d = ST_PASS;
        cnt_d   = '0;
        if (lvl_q == 3'(IRQ_LEVEL) && req_q) begin
          if (prio_m.valid) begin
            sel_d   = prio_m.idx;
            state_d = ST_RESPOND;
          end else if (prio_p.valid) begin
            sel_d   = prio_p.idx;
            state_d = ST_RESPOND;
          end
        end
      end
      ST_RESPOND: begin
        if (as_s)                   state_d = ST_IDLE;   // aborted cycle
        else if (cnt_q == CNT_LAST) state_d = ST_HOLD;
        else                        cnt_d   = cnt_q + 1'b1;
      end
      ST_HOLD: begin
        // A data-strobe release completes the acknowledge even if the address
        // strobe rises in the same cycle; AS alone means the master aborted.
        if (ds_s) begin
          ack_clr = 1'b1;
          state_d = ST_WAIT_END;
        end else if (as_s) begin
          state_d = ST_IDLE;
        end
      end
      ST_PASS: begin
        if (as_s) state_d = ST_WAIT_END;
      end
      ST_WAIT_END: begin
        if (as_s && iack_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Set (new falling edge) wins over the acknowledge clear.
  assign clr8      = ack_clr ? (8'h01 << sel_q) : 8'h00;
  assign pending_d = (pending_q & ~clr8[NUM_SRC-1:0]) | (lint_prev_q & ~lint_s);

  always_ff @(posedge CLOCK or negedge RESETn) begin
    if (!RESETn) begin
      state_q     <= ST_IDLE;
      lint_prev_q <= '1;
      pending_q   <= '0;
      irq_n_q     <= 1'b1;
      as_prev_q   <= 1'b1;
      lvl_q       <= '0;
      req_q       <= 1'b0;
      sel_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      lint_prev_q <= lint_s;
      pending_q   <= pending_d;
      irq_n_q     <= ~|(pending_q & IRQ_MASK);
      as_prev_q   <= as_s;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      // ADDR_LVL is stable on the bus by the time the synced strobe falls;
      // the request decision is frozen here so a later mask change can't
      // withdraw it mid-cycle.
      if (as_prev_q && !as_s) begin
        lvl_q <= ADDR_LVL;
        req_q <= ~irq_n_q;
      end
    end
  end

  assign VEC_OE     = (state_q == ST_RESPOND) || (state_q == ST_HOLD);
  assign VECTOR     = VEC_OE ? (VECTOR_BASE + {5'b0, sel_q}) : 8'h00;
  assign IRQ_DTACKn = (state_q != ST_HOLD);
  assign IACKOUTn   = (state_q == ST_PASS) ? iackin_s : 1'b1;
  assign IRQn       = irq_n_q;
  assign PENDING    = pending_q;

endmodule

// File: tb/tb_vme_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vme_irq_ctrl
// Directed testbench for vme_irq_ctrl with default parameters
// (NUM_SRC=8, IRQ_LEVEL=1, VECTOR_BASE=8'h40, DTACK_DLY=2).
// Inputs are driven 1 ns after the rising edge and outputs sampled there too.
// -----------------------------------------------------------------------------
module tb_vme_irq_ctrl;

  logic       CLOCK    = 1'b0;
  logic       RESETn   = 1'b0;
  logic [7:0] LINTIn   = 8'hFF;
  logic [7:0] IRQ_MASK = 8'hFF;
  logic       VME_ASn  = 1'b1;
  logic       DS0n     = 1'b1;
  logic       IACKn    = 1'b1;
  logic       IACKINn  = 1'b1;
  logic [2:0] ADDR_LVL = 3'd0;
  logic       IACKOUTn, IRQn, VEC_OE, IRQ_DTACKn;
  logic [7:0] VECTOR, PENDING;

  int checks   = 0;
  int failures = 0;

  vme_irq_ctrl #(
    .NUM_SRC     (8),
    .IRQ_LEVEL   (1),
    .VECTOR_BASE (8'h40),
    .DTACK_DLY   (2)
  ) dut (
    .CLOCK      (CLOCK),
    .RESETn     (RESETn),
    .LINTIn     (LINTIn),
    .IRQ_MASK   (IRQ_MASK),
    .VME_ASn    (VME_ASn),
    .DS0n       (DS0n),
    .IACKn      (IACKn),
    .IACKINn    (IACKINn),
    .ADDR_LVL   (ADDR_LVL),
    .IACKOUTn   (IACKOUTn),
    .IRQn       (IRQn),
    .VECTOR     (VECTOR),
    .VEC_OE     (VEC_OE),
    .IRQ_DTACKn (IRQ_DTACKn),
    .PENDING    (PENDING)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic wait_oe(input logic lvl, input string name);
    int n = 0;
    while (VEC_OE !== lvl && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (VEC_OE !== lvl) begin
      failures++;
      $display("FAIL %s wait_vec_oe: got %b want %b after %0d cycles", name, VEC_OE, lvl, n);
    end
  endtask

  task automatic start_iack(input logic [2:0] lvl);
    ADDR_LVL = lvl;
    IACKn    = 1'b0;
    VME_ASn  = 1'b0;
    DS0n     = 1'b0;
  endtask

  task automatic end_iack();
    DS0n    = 1'b1;
    VME_ASn = 1'b1;
    IACKn   = 1'b1;
    repeat (4) tick();
  endtask

  // Full acknowledged IACK cycle on level lvl with vector and DTACK timing checks.
  task automatic do_ack(input logic [2:0] lvl, input logic [7:0] exp_vec,
                        input logic [7:0] exp_pend, input string name);
    start_iack(lvl);
    wait_oe(1'b1, name);
    checks++;
    if (VECTOR !== exp_vec) begin failures++; $display("FAIL %s vector: got %h want %h", name, VECTOR, exp_vec); end
    checks++;
    if (IRQ_DTACKn !== 1'b1) begin failures++; $display("FAIL %s dtack_at_drive: got %b want 1", name, IRQ_DTACKn); end
    tick();
    checks++;
    if (IRQ_DTACKn !== 1'b1) begin failures++; $display("FAIL %s dtack_early: got %b want 1", name, IRQ_DTACKn); end
    tick();
    checks++;
    if (IRQ_DTACKn !== 1'b0) begin failures++; $display("FAIL %s dtack_dly2: got %b want 0", name, IRQ_DTACKn); end
    checks++;
    if (IACKOUTn !== 1'b1) begin failures++; $display("FAIL %s iackout_hold: got %b want 1", name, IACKOUTn); end
    checks++;
    if (VECTOR !== exp_vec) begin failures++; $display("FAIL %s vector_hold: got %h want %h", name, VECTOR, exp_vec); end
    DS0n = 1'b1;
    wait_oe(1'b0, name);
    checks++;
    if (PENDING !== exp_pend) begin failures++; $display("FAIL %s pending_after_ack: got %h want %h", name, PENDING, exp_pend); end
    checks++;
    if (IRQ_DTACKn !== 1'b1 || VECTOR !== 8'h00) begin
      failures++; $display("FAIL %s release: dtack=%b vector=%h want 1/00", name, IRQ_DTACKn, VECTOR);
    end
    end_iack();
  endtask

  task automatic test_reset();
    RESETn = 1'b0;
    repeat (3) tick();
    checks++;
    if ({IACKOUTn, IRQn, VEC_OE, IRQ_DTACKn} !== 4'b1101) begin
      failures++; $display("FAIL reset_ctrl: got iackout,irq,oe,dtack=%b want 1101", {IACKOUTn, IRQn, VEC_OE, IRQ_DTACKn});
    end
    checks++;
    if (VECTOR !== 8'h00) begin failures++; $display("FAIL reset_vector: got %h want 00", VECTOR); end
    checks++;
    if (PENDING !== 8'h00) begin failures++; $display("FAIL reset_pending: got %h want 00", PENDING); end
    RESETn = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_single_source();
    LINTIn = 8'hF7;
    repeat (2) tick();
    checks++;
    if (PENDING !== 8'h00) begin failures++; $display("FAIL single_latency_early: got %h want 00", PENDING); end
    tick();
    checks++;
    if (PENDING !== 8'h08) begin failures++; $display("FAIL single_pending: got %h want 08", PENDING); end
    checks++;
    if (IRQn !== 1'b1) begin failures++; $display("FAIL single_irq_reg: got %b want 1", IRQn); end
    tick();
    checks++;
    if (IRQn !== 1'b0) begin failures++; $display("FAIL single_irq: got %b want 0", IRQn); end
    // Level held low: no re-trigger after the acknowledge.
    do_ack(3'd1, 8'h43, 8'h00, "single");
    repeat (3) tick();
    checks++;
    if (IRQn !== 1'b1 || PENDING !== 8'h00) begin
      failures++; $display("FAIL single_no_retrigger: irq=%b pending=%h want 1/00", IRQn, PENDING);
    end
    LINTIn = 8'hFF;
    repeat (3) tick();
  endtask

  task automatic test_priority();
    LINTIn = 8'hDB;   // bits 5 and 2 fall together
    repeat (4) tick();
    checks++;
    if (PENDING !== 8'h24 || IRQn !== 1'b0) begin
      failures++; $display("FAIL prio_pending: pending=%h irq=%b want 24/0", PENDING, IRQn);
    end
    do_ack(3'd1, 8'h42, 8'h20, "prio_first");
    checks++;
    if (IRQn !== 1'b0) begin failures++; $display("FAIL prio_irq_mid: got %b want 0", IRQn); end
    do_ack(3'd1, 8'h45, 8'h00, "prio_second");
    checks++;
    if (IRQn !== 1'b1) begin failures++; $display("FAIL prio_irq_end: got %b want 1", IRQn); end
    LINTIn = 8'hFF;
    repeat (3) tick();
  endtask

  task automatic test_wrong_level();
    LINTIn = 8'hFD;
    repeat (4) tick();
    checks++;
    if (PENDING !== 8'h02) begin failures++; $display("FAIL wl_pending: got %h want 02", PENDING); end
    IACKINn = 1'b1;
    start_iack(3'd3);
    repeat (6) tick();
    checks++;
    if (VEC_OE !== 1'b0 || IACKOUTn !== 1'b1) begin
      failures++; $display("FAIL wl_pass_idle: oe=%b iackout=%b want 0/1", VEC_OE, IACKOUTn);
    end
    IACKINn = 1'b0;
    repeat (3) tick();
    checks++;
    if (IACKOUTn !== 1'b0) begin failures++; $display("FAIL wl_pass_low: got %b want 0", IACKOUTn); end
    IACKINn = 1'b1;
    repeat (3) tick();
    checks++;
    if (IACKOUTn !== 1'b1) begin failures++; $display("FAIL wl_pass_high: got %b want 1", IACKOUTn); end
    checks++;
    if (PENDING !== 8'h02 || IRQ_DTACKn !== 1'b1 || VEC_OE !== 1'b0) begin
      failures++; $display("FAIL wl_untouched: pending=%h dtack=%b oe=%b want 02/1/0", PENDING, IRQ_DTACKn, VEC_OE);
    end
    end_iack();
    do_ack(3'd1, 8'h41, 8'h00, "wl_cleanup");
    checks++;
    if (IRQn !== 1'b1) begin failures++; $display("FAIL wl_irq_end: got %b want 1", IRQn); end
    LINTIn = 8'hFF;
    repeat (3) tick();
  endtask

  task automatic test_not_requesting();
    start_iack(3'd1);
    repeat (6) tick();
    IACKINn = 1'b0;
    repeat (3) tick();
    checks++;
    if (IACKOUTn !== 1'b0) begin failures++; $display("FAIL nr_pass: got %b want 0", IACKOUTn); end
    checks++;
    if (IRQ_DTACKn !== 1'b1 || VEC_OE !== 1'b0) begin
      failures++; $display("FAIL nr_no_resp: dtack=%b oe=%b want 1/0", IRQ_DTACKn, VEC_OE);
    end
    IACKINn = 1'b1;
    end_iack();
  endtask

  task automatic test_mask_abort();
    IRQ_MASK = 8'h00;
    LINTIn   = 8'hFE;
    repeat (5) tick();
    checks++;
    if (PENDING !== 8'h01 || IRQn !== 1'b1) begin
      failures++; $display("FAIL mask_latch: pending=%h irq=%b want 01/1", PENDING, IRQn);
    end
    IRQ_MASK = 8'hFF;
    repeat (2) tick();
    checks++;
    if (IRQn !== 1'b0) begin failures++; $display("FAIL mask_unmask_irq: got %b want 0", IRQn); end
    start_iack(3'd1);
    wait_oe(1'b1, "abort");
    checks++;
    if (VECTOR !== 8'h40) begin failures++; $display("FAIL abort_vector: got %h want 40", VECTOR); end
    VME_ASn = 1'b1;
    repeat (4) tick();
    checks++;
    if (VEC_OE !== 1'b0 || IRQ_DTACKn !== 1'b1 || VECTOR !== 8'h00) begin
      failures++; $display("FAIL abort_release: oe=%b dtack=%b vector=%h want 0/1/00", VEC_OE, IRQ_DTACKn, VECTOR);
    end
    checks++;
    if (PENDING !== 8'h01) begin failures++; $display("FAIL abort_pending: got %h want 01", PENDING); end
    IACKn = 1'b1;
    DS0n  = 1'b1;
    repeat (3) tick();
  endtask

  // Mask cleared after the request was latched, then reset asserted mid-HOLD.
  task automatic test_mid_reset();
    start_iack(3'd1);
    repeat (3) tick();
    IRQ_MASK = 8'h00;
    wait_oe(1'b1, "mask_cleared");
    checks++;
    if (VECTOR !== 8'h40) begin failures++; $display("FAIL mask_cleared_vector: got %h want 40", VECTOR); end
    repeat (2) tick();
    checks++;
    if (IRQ_DTACKn !== 1'b0) begin failures++; $display("FAIL midrst_in_hold: got %b want 0", IRQ_DTACKn); end
    RESETn = 1'b0;
    #1;
    checks++;
    if ({IACKOUTn, IRQn, VEC_OE, IRQ_DTACKn} !== 4'b1101) begin
      failures++; $display("FAIL midrst_ctrl: got iackout,irq,oe,dtack=%b want 1101", {IACKOUTn, IRQn, VEC_OE, IRQ_DTACKn});
    end
    checks++;
    if (PENDING !== 8'h00 || VECTOR !== 8'h00) begin
      failures++; $display("FAIL midrst_data: pending=%h vector=%h want 00/00", PENDING, VECTOR);
    end
    LINTIn   = 8'hFF;
    IRQ_MASK = 8'hFF;
    VME_ASn  = 1'b1;
    DS0n     = 1'b1;
    IACKn    = 1'b1;
    tick();
    RESETn = 1'b1;
    repeat (3) tick();
  endtask

  initial begin
    test_reset();
    test_single_source();
    test_priority();
    test_wrong_level();
    test_not_requesting();
    test_mask_abort();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vme_irq_ctrl.md
Name: vme_irq_ctrl

Overview:
- VME interrupter (ROAK, D08(O)) that turns the eight active-low local interrupt lines LINTIn[7:0] into a single VME IRQ request.
- Answers IACK cycles on its level with an 8-bit status/ID vector, or passes the IACK daisy chain onward.
- Sits beside vme_slave, drives the board IRQ1n pin, and shares the VME data buffer and DTACKn via the top-level muxes.

Parameters:
- NUM_SRC, 8, number of local interrupt sources; 1..8.
- IRQ_LEVEL, 1, VME level (1..7) compared against A[3:1] during IACK.
- VECTOR_BASE, 8'h40, vector base; vector returned = VECTOR_BASE + source index.
- DTACK_DLY, 2, CLOCK cycles from vector drive to DTACK assertion; >=1.

Ports:
- CLOCK  in  1  system clock.
- RESETn  in  1  asynchronous active-low reset.
- LINTIn  in  NUM_SRC  local interrupts, active low, asynchronous.
- IRQ_MASK  in  NUM_SRC  1 = source enabled; from the control register.
- VME_ASn  in  1  VME address strobe, asynchronous.
- DS0n  in  1  VME data strobe 0, asynchronous.
- IACKn  in  1  VME IACK, asynchronous; low marks an IACK cycle.
- IACKINn  in  1  daisy-chain input, asynchronous.
- ADDR_LVL  in  3  VME A[3:1] during IACK.
- IACKOUTn  out  1  daisy-chain output.
- IRQn  out  1  request to the IRQ1n pin, active low.
- VECTOR  out  8  status/ID byte for DATA_BUS[7:0].
- VEC_OE  out  1  1 = drive VECTOR onto the VME data buffer.
- IRQ_DTACKn  out  1  DTACK contribution, active low; ANDed at top.
- PENDING  out  NUM_SRC  latched pending bits, for status readback.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (ports CLOCK, RESETn).
- Reset values: IACKOUTn=1, IRQn=1, VECTOR=0, VEC_OE=0, IRQ_DTACKn=1, PENDING=0, FSM=IDLE.
- Synchronisation: all asynchronous inputs (LINTIn, VME_ASn, DS0n, IACKn, IACKINn) pass through 2-flop synchronisers. ADDR_LVL is sampled when synced VME_ASn falls.

Pending bits:
- A 1->0 edge of synced LINTIn[i] sets PENDING[i] on the next cycle. Latency from pin to PENDING is 3 cycles.
- A level held low does not re-trigger.
- PENDING[i] clears only when its vector is acknowledged. If a new edge on the same bit arrives in the clear cycle, set wins.
- Masked sources still latch but do not request.
- IRQn = ~|(PENDING & IRQ_MASK), registered.

FSM states: IDLE, ARB, RESPOND, HOLD, PASS, WAIT_END.
- IDLE -> ARB when synced IACKn=0, VME_ASn=0 and DS0n=0.
- ARB, single cycle:
  - If ADDR_LVL==IRQ_LEVEL and IRQn was 0 at VME_ASn fall, latch sel = lowest set index of PENDING&IRQ_MASK; index 0 has highest priority. Go to RESPOND.
  - Otherwise go to PASS.
- RESPOND: VECTOR=VECTOR_BASE+sel, VEC_OE=1. After DTACK_DLY cycles assert IRQ_DTACKn=0 and go to HOLD.
- HOLD: keep VECTOR, VEC_OE and IRQ_DTACKn. When synced DS0n=1:
  - deassert all three;
  - clear PENDING[sel] (ROAK);
  - go to WAIT_END.
- PASS: IACKOUTn = synced IACKINn (pass-through). Go to WAIT_END when synced VME_ASn=1.
- WAIT_END: IACKOUTn=1. Go to IDLE when synced VME_ASn=1 and IACKn=1.
- IACKOUTn is never 0 in RESPOND or HOLD.

Boundary conditions:
- Mask cleared between IRQ and IACK: the latched IRQn decision stands, and the vector of the lowest PENDING bit is still returned.
- Aborted cycle: VME_ASn rises during RESPOND or HOLD -> release all outputs at once, PENDING unchanged, go to IDLE.
- Mid-operation reset: all outputs return immediately to their reset values.
- NUM_SRC<8: unused upper LINTIn are absent and treated as inactive.

Decomposition:
- Package vme_irq_pkg holds:
  - the FSM state enum;
  - the synchroniser depth constant (2);
  - a priority-encoder function returning index and valid.
- Sub-module vme_irq_sync: generic N-bit 2-flop synchroniser, reused for LINTIn and the VME strobes.

Test Plan:
- Reset: RESETn=0 mid-HOLD -> IRQn=1, IRQ_DTACKn=1, VEC_OE=0, PENDING=0 immediately.
- Single source: LINTIn[3] falls, IRQ_MASK=8'hFF -> PENDING=8'h08 after 3 cycles, then IRQn=0. IACK with ADDR_LVL=1, DS0n low -> VECTOR=8'h43, IRQ_DTACKn=0 2 cycles later. DS0n high -> PENDING=0, IRQn=1.
- Priority: LINTIn[5] and LINTIn[2] fall together -> first IACK returns 8'h42, second returns 8'h45, then IRQn=1.
- Wrong level: IACK with ADDR_LVL=3 while pending -> IACKOUTn follows IACKINn, VEC_OE stays 0, PENDING unchanged.
- Not requesting: PENDING=0, IACK level 1 -> IACKOUTn passes; IRQ_DTACKn stays 1.
- Mask and abort: IRQ_MASK=0 with LINTIn[0] edge -> PENDING[0]=1, IRQn=1. Unmask, start IACK, drop VME_ASn during RESPOND -> outputs released, PENDING[0] still 1.
